// File: rtl/ifu_ifetch.sv
// rtl/ifu_ifetch.sv - IFU fetch control: PC register, single-outstanding fetch handshake, IR and next-PC selection.
module ifu_ifetch #(
  parameter int                 PC_SIZE  = 32,
  parameter logic [PC_SIZE-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               ifu_req_valid,
  input  logic               ifu_req_ready,
  output logic [PC_SIZE-1:0] ifu_req_pc,
  input  logic               ifu_rsp_valid,
  output logic               ifu_rsp_ready,
  input  logic [31:0]        ifu_rsp_instr,
  input  logic               ifu_rsp_err,
  output logic               ir_valid,
  output logic [31:0]        ir_instr,
  output logic [PC_SIZE-1:0] ir_pc,
  output logic               ir_err,
  input  logic               ir_ready,
  input  logic               prdt_taken,
  input  logic [PC_SIZE-1:0] prdt_pc_add_op1,
  input  logic [PC_SIZE-1:0] prdt_pc_add_op2,
  input  logic               bpu_wait,
  input  logic               pipe_flush_req,
  input  logic [PC_SIZE-1:0] pipe_flush_pc,
  output logic               pipe_flush_ack
);

  typedef enum logic [1:0] {ST_RST, ST_REQ, ST_WAIT, ST_NXT} state_t;

  state_t             state, state_nxt;
  logic [PC_SIZE-1:0] pc, pc_nxt;
  logic               drop_rsp, drop_nxt;
  logic               req_hsk, rsp_hsk, ir_load;

  assign ifu_req_valid  = (state == ST_REQ);
  assign ifu_req_pc     = pc;
  assign pipe_flush_ack = pipe_flush_req;
  // A response owed to a flushed request is always swallowed, regardless of IR occupancy.
  assign ifu_rsp_ready  = (state == ST_WAIT) & (drop_rsp | ~ir_valid | ir_ready);
  assign req_hsk        = ifu_req_valid & ifu_req_ready;
  assign rsp_hsk        = ifu_rsp_valid & ifu_rsp_ready;
  assign ir_load        = (state == ST_WAIT) & rsp_hsk & ~drop_rsp & ~pipe_flush_req;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    drop_nxt  = drop_rsp;
    if (pipe_flush_req) begin
      pc_nxt = pipe_flush_pc;
      // If the outstanding response completes in the flush cycle, nothing is left to drop.
      if ((state == ST_WAIT) && rsp_hsk) begin
        state_nxt = ST_REQ;
        drop_nxt  = 1'b0;
      end else if ((state == ST_WAIT) || req_hsk) begin
        state_nxt = ST_WAIT;
        drop_nxt  = 1'b1;
      end else begin
        state_nxt = ST_REQ;
        drop_nxt  = 1'b0;
      end
    end else begin
      case (state)
        ST_RST: state_nxt = ST_REQ;
        ST_REQ: if (req_hsk) state_nxt = ST_WAIT;
        ST_WAIT: begin
          if (rsp_hsk) begin
            state_nxt = drop_rsp ? ST_REQ : ST_NXT;
            drop_nxt  = 1'b0;
          end
        end
        ST_NXT: begin
          if (!bpu_wait) begin
            pc_nxt    = prdt_taken ? (prdt_pc_add_op1 + prdt_pc_add_op2) : (ir_pc + PC_SIZE'(4));
            state_nxt = ST_REQ;
          end
        end
        default: state_nxt = ST_RST;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RST;
      pc       <= RESET_PC;
      drop_rsp <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      drop_rsp <= drop_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_valid <= 1'b0;
      ir_instr <= 32'h0;
      ir_pc    <= '0;
      ir_err   <= 1'b0;
    end else if (pipe_flush_req) begin
      ir_valid <= 1'b0;
    end else if (ir_load) begin
      ir_valid <= 1'b1;
      ir_instr <= ifu_rsp_instr;
      ir_pc    <= pc;
      ir_err   <= ifu_rsp_err;
    end else if (ir_valid && ir_ready) begin
      ir_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ifu_ifetch.sv
// tb/tb_ifu_ifetch.sv - Scoreboarded bench for ifu_ifetch with a latency-programmable fetch responder.
module tb_ifu_ifetch;

  logic        clk;
  logic        rst_n;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_pc;
  logic        ifu_rsp_valid, ifu_rsp_ready;
  logic [31:0] ifu_rsp_instr;
  logic        ifu_rsp_err;
  logic        ir_valid;
  logic [31:0] ir_instr, ir_pc;
  logic        ir_err, ir_ready;
  logic        prdt_taken;
  logic [31:0] prdt_pc_add_op1, prdt_pc_add_op2;
  logic        bpu_wait;
  logic        pipe_flush_req;
  logic [31:0] pipe_flush_pc;
  logic        pipe_flush_ack;

  ifu_ifetch dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_pc(ifu_req_pc),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
    .ifu_rsp_instr(ifu_rsp_instr), .ifu_rsp_err(ifu_rsp_err),
    .ir_valid(ir_valid), .ir_instr(ir_instr), .ir_pc(ir_pc), .ir_err(ir_err), .ir_ready(ir_ready),
    .prdt_taken(prdt_taken), .prdt_pc_add_op1(prdt_pc_add_op1), .prdt_pc_add_op2(prdt_pc_add_op2),
    .bpu_wait(bpu_wait),
    .pipe_flush_req(pipe_flush_req), .pipe_flush_pc(pipe_flush_pc), .pipe_flush_ack(pipe_flush_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] exp_req[$];

  // Responder state: a request handshake arms a response rsp_lat cycles later.
  logic        pend = 1'b0;
  int          cnt = 0;
  int          rsp_lat = 0;
  logic [31:0] rsp_instr = 32'h0000_0013;
  logic        rsp_err = 1'b0;
  logic        req_hs_f, rsp_hs_f;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cycle();
    if (pend && cnt == 0) ifu_rsp_valid = 1'b1;
    else begin
      ifu_rsp_valid = 1'b0;
      if (pend) cnt--;
    end
    ifu_rsp_instr = rsp_instr;
    ifu_rsp_err   = rsp_err;
    #3;
    req_hs_f = rst_n & ifu_req_valid & ifu_req_ready;
    rsp_hs_f = rst_n & ifu_rsp_valid & ifu_rsp_ready;
    @(posedge clk);
    cyc++;
    if (rsp_hs_f) pend = 1'b0;
    if (req_hs_f) begin
      pend = 1'b1;
      cnt  = rsp_lat;
    end
    @(negedge clk);
  endtask

  task automatic run_reqs(input int n, input int bound);
    int seen = 0;
    for (int i = 0; i < bound && seen < n; i++) begin
      cycle();
      if (req_hs_f) seen++;
    end
    if (seen < n) begin
      total++;
      bad++;
      $display("FAIL req_timeout actual=%0d required=%0d", seen, n);
    end
  endtask

  // Monitor: every request handshake must match the next scoreboard entry.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && ifu_req_valid && ifu_req_ready) begin
        total++;
        if (exp_req.size() == 0) begin
          bad++;
          $display("FAIL req_unexpected actual=%h required=none", ifu_req_pc);
        end else begin
          logic [31:0] e;
          e = exp_req.pop_front();
          if (ifu_req_pc !== e) begin
            bad++;
            $display("FAIL req_pc actual=%h required=%h (t=%0t)", ifu_req_pc, e, $time);
          end
        end
      end
    end
  end

  initial begin
    int hc[3];
    rst_n = 1'b0;
    ifu_req_ready = 1'b1;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_instr = 32'h0;
    ifu_rsp_err = 1'b0;
    ir_ready = 1'b1;
    prdt_taken = 1'b0;
    prdt_pc_add_op1 = 32'h0;
    prdt_pc_add_op2 = 32'h0;
    bpu_wait = 1'b0;
    pipe_flush_req = 1'b0;
    pipe_flush_pc = 32'h0;
    repeat (2) @(negedge clk);

    chk("rst_req_valid", {31'h0, ifu_req_valid}, 32'h0);
    chk("rst_rsp_ready", {31'h0, ifu_rsp_ready}, 32'h0);
    chk("rst_ir_valid", {31'h0, ir_valid}, 32'h0);
    chk("rst_ir_instr", ir_instr, 32'h0);
    chk("rst_ir_pc", ir_pc, 32'h0);
    chk("rst_ir_err", {31'h0, ir_err}, 32'h0);
    chk("rst_req_pc", ifu_req_pc, 32'h8000_0000);

    // Reset release and sequential fetch.
    rst_n = 1'b1;
    #1 chk("first_cycle_no_req", {31'h0, ifu_req_valid}, 32'h0);
    cycle();
    chk("second_cycle_req", {31'h0, ifu_req_valid}, 32'h1);
    exp_req.push_back(32'h8000_0000);
    exp_req.push_back(32'h8000_0004);
    exp_req.push_back(32'h8000_0008);
    for (int k = 0; k < 3; k++) begin
      run_reqs(1, 10);
      hc[k] = cyc;
      if (k > 0) chk("seq_ir_pc", ir_pc, 32'h8000_0000 + 32'(4 * (k - 1)));
    end
    chk("seq_spacing_01", 32'(hc[1] - hc[0]), 32'd3);
    chk("seq_spacing_12", 32'(hc[2] - hc[1]), 32'd3);
    chk("seq_ir_instr", ir_instr, 32'h0000_0013);
    chk("seq_ir_err", {31'h0, ir_err}, 32'h0);

    // Taken prediction, with adder wrap and without.
    exp_req.push_back(32'h8000_000C);
    exp_req.push_back(32'h8000_0010);
    run_reqs(2, 20);
    prdt_taken = 1'b1;
    prdt_pc_add_op1 = 32'h8000_0010;
    prdt_pc_add_op2 = 32'hFFFF_FFF0;
    exp_req.push_back(32'h8000_0000);
    run_reqs(1, 10);
    prdt_pc_add_op2 = 32'h0000_0020;
    exp_req.push_back(32'h8000_0030);
    run_reqs(1, 10);
    prdt_taken = 1'b0;

    // bpu_wait stall in NXT.
    bpu_wait = 1'b1;
    exp_req.push_back(32'h8000_0034);
    cycle();
    chk("bpu_ir_loaded", {31'h0, ir_valid}, 32'h1);
    chk("bpu_ir_pc", ir_pc, 32'h8000_0030);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bpu_stall_no_req", {31'h0, ifu_req_valid}, 32'h0);
    end
    bpu_wait = 1'b0;
    cycle();
    chk("bpu_release_req", {31'h0, ifu_req_valid}, 32'h1);
    chk("bpu_release_pc", ifu_req_pc, 32'h8000_0034);

    // IR backpressure holds the response off.
    ir_ready = 1'b0;
    cycle();
    cycle();
    rsp_instr = 32'h1234_5678;
    rsp_err = 1'b1;
    exp_req.push_back(32'h8000_0038);
    run_reqs(1, 10);
    cycle();
    cycle();
    chk("bp_rsp_ready_low", {31'h0, ifu_rsp_ready}, 32'h0);
    chk("bp_ir_valid", {31'h0, ir_valid}, 32'h1);
    chk("bp_ir_pc_held", ir_pc, 32'h8000_0034);
    chk("bp_ir_instr_held", ir_instr, 32'h0000_0013);
    ir_ready = 1'b1;
    #1 chk("bp_rsp_ready_high", {31'h0, ifu_rsp_ready}, 32'h1);
    cycle();
    chk("bp_ir_valid_kept", {31'h0, ir_valid}, 32'h1);
    chk("bp_ir_pc_new", ir_pc, 32'h8000_0038);
    chk("bp_ir_instr_new", ir_instr, 32'h1234_5678);
    chk("bp_ir_err", {31'h0, ir_err}, 32'h1);
    rsp_instr = 32'h0000_0013;
    rsp_err = 1'b0;

    // Flush while waiting for a response.
    ir_ready = 1'b0;
    rsp_lat = 2;
    exp_req.push_back(32'h8000_003C);
    run_reqs(1, 10);
    pipe_flush_req = 1'b1;
    pipe_flush_pc = 32'h8000_0100;
    #1 chk("flush_ack", {31'h0, pipe_flush_ack}, 32'h1);
    cycle();
    pipe_flush_req = 1'b0;
    ir_ready = 1'b1;
    rsp_lat = 0;
    chk("flush_ir_invalid", {31'h0, ir_valid}, 32'h0);
    chk("flush_no_req_while_drop", {31'h0, ifu_req_valid}, 32'h0);
    chk("flush_pc", ifu_req_pc, 32'h8000_0100);
    exp_req.push_back(32'h8000_0100);
    run_reqs(1, 10);
    chk("flush_dropped_not_loaded", {31'h0, ir_valid}, 32'h0);
    cycle();
    chk("flush_target_loaded", {31'h0, ir_valid}, 32'h1);
    chk("flush_target_ir_pc", ir_pc, 32'h8000_0100);

    // Flush coincident with a request handshake.
    ir_ready = 1'b0;
    cycle();
    chk("co_req_pc", ifu_req_pc, 32'h8000_0104);
    exp_req.push_back(32'h8000_0104);
    rsp_lat = 1;
    pipe_flush_req = 1'b1;
    pipe_flush_pc = 32'h8000_0200;
    cycle();
    pipe_flush_req = 1'b0;
    chk("co_ir_invalid", {31'h0, ir_valid}, 32'h0);
    chk("co_no_req_while_drop", {31'h0, ifu_req_valid}, 32'h0);
    chk("co_pc", ifu_req_pc, 32'h8000_0200);
    exp_req.push_back(32'h8000_0200);
    run_reqs(1, 10);
    chk("co_dropped_not_loaded", {31'h0, ir_valid}, 32'h0);
    chk("co_ir_pc_kept", ir_pc, 32'h8000_0100);
    ir_ready = 1'b1;

    // Asynchronous reset while a response is outstanding.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req_valid", {31'h0, ifu_req_valid}, 32'h0);
    chk("arst_rsp_ready", {31'h0, ifu_rsp_ready}, 32'h0);
    chk("arst_ir_pc", ir_pc, 32'h0);
    chk("arst_ir_instr", ir_instr, 32'h0);
    chk("arst_req_pc", ifu_req_pc, 32'h8000_0000);
    pend = 1'b0;
    ifu_rsp_valid = 1'b0;
    rsp_lat = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    exp_req.push_back(32'h8000_0000);
    run_reqs(1, 10);
    cycle();
    chk("post_rst_ir_pc", ir_pc, 32'h8000_0000);
    chk("scoreboard_drained", 32'(exp_req.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1);
  end

endmodule

// File: doc/ifu_ifetch.md
# ifu_ifetch

Fetch-control stage of the IFU, sitting directly upstream of the lite branch predictor. It owns the PC register and the single-outstanding instruction-fetch request/response handshake. It loads returned instructions into the IR and computes the next PC from the predictor's taken flag and adder operands, honouring `bpu_wait` stalls. It also accepts pipeline flushes from the EXU.

## Interface
Parameters:
- `PC_SIZE`, 32, PC and address width.
- `RESET_PC`, 32'h8000_0000, first fetch address after reset.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ifu_req_valid` out 1: fetch request valid.
- `ifu_req_ready` in 1: fetch port accepts the request.
- `ifu_req_pc` out PC_SIZE: fetch address; always equals the PC register.
- `ifu_rsp_valid` in 1: fetch response valid.
- `ifu_rsp_ready` out 1: response accepted this cycle.
- `ifu_rsp_instr` in 32: fetched instruction.
- `ifu_rsp_err` in 1: bus error on the fetch.
- `ir_valid` out 1: IR holds an instruction.
- `ir_instr` out 32: IR instruction; feeds minidecode and the predictor.
- `ir_pc` out PC_SIZE: PC of the IR instruction.
- `ir_err` out 1: fetch error for the IR instruction.
- `ir_ready` in 1: downstream consumes the IR this cycle.
- `prdt_taken` in 1: predictor taken flag for the IR instruction.
- `prdt_pc_add_op1` in PC_SIZE: predictor next-PC adder operand 1.
- `prdt_pc_add_op2` in PC_SIZE: predictor next-PC adder operand 2.
- `bpu_wait` in 1: predictor cannot yet resolve the target (jalr dependency).
- `pipe_flush_req` in 1: EXU redirect.
- `pipe_flush_pc` in PC_SIZE: redirect target.
- `pipe_flush_ack` out 1: flush accepted; combinationally equal to `pipe_flush_req`.

## Operation
- States:
  - RST: entered on reset; no request.
  - REQ: `ifu_req_valid`=1.
  - WAIT_RSP: one request outstanding.
  - NXT: IR loaded; next PC is being resolved.
- RST -> REQ unconditionally after one cycle.
- REQ -> WAIT_RSP on `ifu_req_valid & ifu_req_ready`. The PC is held stable while waiting, except on a flush.
- WAIT_RSP:
  - `ifu_rsp_ready = ~ir_valid | ir_ready`.
  - On response handshake: IR <= {instr, PC register, err}, `ir_valid` <= 1, -> NXT.
- NXT:
  - If `bpu_wait`=1, stay and hold the PC.
  - Otherwise PC <= `prdt_taken ? prdt_pc_add_op1 + prdt_pc_add_op2 : ir_pc + 4`, -> REQ.
- Adder: PC_SIZE-bit, modulo 2^PC_SIZE; carry out discarded.
- IR:
  - `ir_valid` clears on `ir_valid & ir_ready` unless reloaded in the same cycle.
  - Load and consume in the same cycle leaves `ir_valid`=1 holding the new contents.
  - The IR is overwritten only through the response handshake, so an unconsumed IR is never lost.
- Flush (accepted in any state, ack in the same cycle):
  - IR is invalidated and PC <= `pipe_flush_pc`.
  - RST/NXT/REQ without a same-cycle request handshake: -> REQ; the next-cycle request carries `pipe_flush_pc`. Retracting an un-accepted request is permitted.
  - REQ with a same-cycle `ifu_req_ready`, or WAIT_RSP: set `drop_rsp`, -> WAIT_RSP.
  - While `drop_rsp`=1: `ifu_rsp_ready`=1; the response is discarded (no IR load); `drop_rsp` clears; -> REQ.
  - A flush in the same cycle as a normal response wins: the response is dropped and the IR is not loaded.
  - A flush during NXT overrides `bpu_wait` and the predictor result.
- Errors: `ir_err` is carried to the EXU only; fetch flow is unchanged.
- Async reset mid-transaction: all state returns to reset values immediately; any in-flight response is the fabric's concern.

## Timing
- Reset values:
  - state=RST, PC=RESET_PC, `drop_rsp`=0.
  - `ifu_req_valid`=0, `ifu_rsp_ready`=0.
  - `ir_valid`=0, `ir_instr`=0, `ir_pc`=0, `ir_err`=0.
- First `ifu_req_valid` is in the 2nd cycle after `rst_n` deasserts.
- Response handshake in cycle N -> `ir_valid` in N+1 -> next `ifu_req_valid` in N+2 (if `bpu_wait`=0).
- Each cycle of `bpu_wait` in NXT adds one cycle.
- Flush in cycle N (no outstanding request) -> `ifu_req_valid` with `ifu_req_pc=pipe_flush_pc` in N+1.
- At most one outstanding request at any time.
- `ifu_req_valid`, `ifu_req_pc` and `ir_*` are registered outputs.
- `ifu_rsp_ready` and `pipe_flush_ack` are combinational.

## Test plan
- Reset release, `ifu_req_ready`=1, response `ifu_rsp_instr`=32'h0000_0013 after 1 cycle, `prdt_taken`=0 -> requests at 8000_0000, 8000_0004, 8000_0008, three cycles apart; `ir_pc` tracks them.
- IR at 8000_0010, `prdt_taken`=1, op1=8000_0010, op2=FFFF_FFF0 -> next `ifu_req_pc`=8000_0000. Repeat with op2=0000_0020 -> 8000_0030.
- Hold `bpu_wait`=1 for 3 cycles in NXT -> no request for those cycles; request issues the cycle after `bpu_wait` falls.
- `ir_ready`=0 with `ir_valid`=1 and a response pending -> `ifu_rsp_ready`=0 and IR unchanged. Raise `ir_ready` -> response loaded the same cycle; `ir_valid` stays 1.
- Flush to 8000_0100 while in WAIT_RSP -> `pipe_flush_ack`=1, `ir_valid`=0; pending response discarded; next request at 8000_0100.
- Flush coincident with a request handshake -> `drop_rsp` set; that response is dropped; following request at the flush PC. Also: assert `rst_n`=0 mid-WAIT_RSP -> all outputs return to reset values asynchronously.
